// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the two-port ALU request arbiter:
//   - opcode encodings ALU_ADD .. ALU_NOT
//   - operand / opcode / result widths
//   - sequencer state type
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int OPND_W = 4;  // operand width
  localparam int OP_W   = 3;  // opcode width
  localparam int RES_W  = 8;  // result width

  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_MUL = 3'b010;
  localparam logic [OP_W-1:0] ALU_DIV = 3'b011;
  localparam logic [OP_W-1:0] ALU_AND = 3'b100;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b101;
  localparam logic [OP_W-1:0] ALU_XOR = 3'b110;
  localparam logic [OP_W-1:0] ALU_NOT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu4_core.sv
// ---------------------------------------------------------------------------
// alu4_core
// Purely combinational 4-bit ALU with an 8-bit result.
// Ports:
//   op     in  3  opcode (alu_pkg encodings)
//   a, b   in  4  unsigned operands
//   result out 8  ALU result (upper nibble 0 except MUL / DIV)
//   carry  out 1  ADD carry-out, SUB not-borrow
//   ovf    out 1  signed overflow for ADD / SUB
//   dz     out 1  divide by zero
// ---------------------------------------------------------------------------
module alu4_core
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [RES_W-1:0]  result,
  output logic              carry,
  output logic              ovf,
  output logic              dz
);

  logic [OPND_W:0] sum;
  logic [OPND_W:0] diff;

  // Operation decode; all flags default to 0.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = 8'h00;
    carry  = 1'b0;
    ovf    = 1'b0;
    dz     = 1'b0;
    case (op)
      ALU_ADD: begin
        result = {4'h0, sum[3:0]};
        carry  = sum[4];
        ovf    = (a[3] == b[3]) && (sum[3] != a[3]);
      end
      ALU_SUB: begin
        result = {4'h0, diff[3:0]};
        // bit 4 of the 5-bit difference is the borrow; carry is its inverse
        carry  = ~diff[4];
        ovf    = (a[3] != b[3]) && (diff[3] != a[3]);
      end
      ALU_MUL: begin
        result = {4'h0, a} * {4'h0, b};
      end
      ALU_DIV: begin
        if (b == 4'h0) begin
          result = 8'h00;
          dz     = 1'b1;
        end else begin
          result = {a % b, a / b};
        end
      end
      ALU_AND: result = {4'h0, a & b};
      ALU_OR:  result = {4'h0, a | b};
      ALU_XOR: result = {4'h0, a ^ b};
      ALU_NOT: result = {4'h0, ~a};
      default: result = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter
// Round-robin arbiter and sequencer sharing one 4-bit ALU between two
// requesters. IDLE grants and latches a request, EXEC registers the ALU
// result, RESP holds the response until the owning port consumes it.
// Ports:
//   clk, rst    in   1  clock, synchronous active-high reset
//   req_valid   in   2  per-port request valid
//   req_op      in   6  {op1, op0}
//   req_a       in   8  {a1, a0}
//   req_b       in   8  {b1, b0}
//   req_ready   out  2  grant (combinational on req_valid, IDLE only)
//   rsp_valid   out  2  one-hot response owner
//   rsp_ready   in   2  per-port response consume
//   rsp_result  out  8  ALU result
//   rsp_carry   out  1  carry / not-borrow
//   rsp_ovf     out  1  signed overflow
//   rsp_dz      out  1  divide by zero
// ---------------------------------------------------------------------------
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter bit RST_GRANT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [5:0]       req_op,
  input  logic [7:0]       req_a,
  input  logic [7:0]       req_b,
  output logic [1:0]       req_ready,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [RES_W-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic             rsp_dz
);

  state_t              state;
  logic                last_grant;
  logic                owner;
  logic [OP_W-1:0]     op_q;
  logic [OPND_W-1:0]   a_q;
  logic [OPND_W-1:0]   b_q;

  logic                grant;
  logic                grant_ptr;
  logic [RES_W-1:0]    alu_result;
  logic                alu_carry;
  logic                alu_ovf;
  logic                alu_dz;

  // Round-robin pick: a lone requester wins, a tie goes away from last_grant.
  // While reset is asserted the pointer is shown at its reset value.
  always_comb begin
    grant_ptr = rst ? RST_GRANT : last_grant;
    grant     = 1'b0;
    if (req_valid == 2'b11) begin
      grant = ~grant_ptr;
    end else if (req_valid[1]) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
  end

  // Ready is only offered in IDLE (or under reset, which forces IDLE).
  always_comb begin
    req_ready = 2'b00;
    if (((state == ST_IDLE) || rst) && (req_valid != 2'b00)) begin
      req_ready = grant ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
  end

  alu4_core u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .carry  (alu_carry),
    .ovf    (alu_ovf),
    .dz     (alu_dz)
  );

  // Sequencer FSM with operand latches and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= RST_GRANT;
      owner      <= 1'b0;
      op_q       <= 3'b000;
      a_q        <= 4'h0;
      b_q        <= 4'h0;
      rsp_valid  <= 2'b00;
      rsp_result <= 8'h00;
      rsp_carry  <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_dz     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid != 2'b00) begin
            owner      <= grant;
            last_grant <= grant;
            op_q       <= grant ? req_op[5:3] : req_op[2:0];
            a_q        <= grant ? req_a[7:4]  : req_a[3:0];
            b_q        <= grant ? req_b[7:4]  : req_b[3:0];
            state      <= ST_EXEC;
          end else begin
            state      <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          rsp_result <= alu_result;
          rsp_carry  <= alu_carry;
          rsp_ovf    <= alu_ovf;
          rsp_dz     <= alu_dz;
          rsp_valid  <= owner ? 2'b10 : 2'b01;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          // only the owner's rsp_ready can retire the response
          if (rsp_ready[owner]) begin
            rsp_valid <= 2'b00;
            state     <= ST_IDLE;
          end else begin
            state     <= ST_RESP;
          end
        end
        default: begin
          rsp_valid <= 2'b00;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_req_arbiter
// Scoreboard bench: expected responses are queued at each accept and
// compared when the owning port consumes a response.
// ---------------------------------------------------------------------------
module tb_alu_req_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [5:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_ovf;
  logic       rsp_dz;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] exp_q[$];   // {dz, ovf, carry, result}
  int          port_q[$];

  alu_req_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_ovf    (rsp_ovf),
    .rsp_dz     (rsp_dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model using signed integer arithmetic for the overflow flags.
  function automatic logic [10:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, sa, sb, r;
    logic [7:0] res;
    logic c, o, d;
    ia = int'(a);
    ib = int'(b);
    sa = (ia > 7) ? ia - 16 : ia;
    sb = (ib > 7) ? ib - 16 : ib;
    res = 8'h00; c = 1'b0; o = 1'b0; d = 1'b0;
    case (op)
      3'd0: begin r = ia + ib; res = 8'(r % 16); c = (r > 15); o = ((sa + sb) > 7) || ((sa + sb) < -8); end
      3'd1: begin r = ia - ib; res = 8'((r + 16) % 16); c = (ia >= ib); o = ((sa - sb) > 7) || ((sa - sb) < -8); end
      3'd2: res = 8'(ia * ib);
      3'd3: if (ib == 0) d = 1'b1; else res = 8'((ia % ib) * 16 + ia / ib);
      3'd4: res = {4'h0, a & b};
      3'd5: res = {4'h0, a | b};
      3'd6: res = {4'h0, a ^ b};
      3'd7: res = 8'(15 - ia);
      default: res = 8'h00;
    endcase
    return {d, o, c, res};
  endfunction

  // Response monitor: compares whenever the owner consumes a response.
  always @(negedge clk) begin
    #2;
    if (!rst && ((rsp_valid & rsp_ready) != 2'b00)) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        logic [10:0] e;
        int pp;
        e  = exp_q.pop_front();
        pp = port_q.pop_front();
        check("rsp_port",   32'(rsp_valid),  (pp == 1) ? 32'd2 : 32'd1);
        check("rsp_result", 32'(rsp_result), 32'(e[7:0]));
        check("rsp_carry",  32'(rsp_carry),  32'(e[8]));
        check("rsp_ovf",    32'(rsp_ovf),    32'(e[9]));
        check("rsp_dz",     32'(rsp_dz),     32'(e[10]));
      end
    end
  end

  task automatic set_port(input int p, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    req_op[p*3 +: 3] = op;
    req_a[p*4 +: 4]  = a;
    req_b[p*4 +: 4]  = b;
  endtask

  // Issue one request on port p, queue its expectation, optionally check latency.
  task automatic send(input int p, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [10:0] exp, input bit chk_lat);
    int n;
    n = 0;
    @(negedge clk);
    set_port(p, op, a, b);
    req_valid[p] = 1'b1;
    #1;
    while (!req_ready[p] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) begin
      check("accept_timeout", 32'(n), 32'd0);
      req_valid[p] = 1'b0;
    end else begin
      exp_q.push_back(exp);
      port_q.push_back(p);
      @(posedge clk); #1;
      req_valid[p] = 1'b0;
      // scramble operands after accept; the result must not change
      set_port(p, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if (chk_lat) begin
        @(negedge clk);
        check("lat_exec", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("lat_resp", 32'(rsp_valid), (p == 1) ? 32'd2 : 32'd1);
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((rsp_valid != 2'b00 || exp_q.size() != 0) && n < 40) begin
      @(negedge clk); #3; n++;
    end
    if (n >= 40) check("idle_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    int k, n;
    rst       = 1'b1;
    req_valid = 2'b00;
    req_op    = 6'd0;
    req_a     = 8'd0;
    req_b     = 8'd0;
    rsp_ready = 2'b11;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid),  32'd0);
    check("rst_result",    32'(rsp_result), 32'd0);
    check("rst_flags",     32'({rsp_dz, rsp_ovf, rsp_carry}), 32'd0);
    check("rst_ready_idle", 32'(req_ready), 32'd0);
    req_valid = 2'b11; #1;
    check("rst_ready_tie", 32'(req_ready), 32'd1);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    // directed cases with constant expectations
    send(0, 3'd0, 4'd9,  4'd8, 11'h301, 1'b1); wait_idle();
    send(1, 3'd1, 4'd3,  4'd5, 11'h00E, 1'b1); wait_idle();
    send(1, 3'd2, 4'd15, 4'd15, 11'h0E1, 1'b1); wait_idle();
    send(0, 3'd3, 4'd13, 4'd4, 11'h013, 1'b1); wait_idle();
    send(0, 3'd3, 4'd7,  4'd0, 11'h400, 1'b1); wait_idle();
    send(1, 3'd7, 4'h5,  4'h0, 11'h00A, 1'b1); wait_idle();

    // random requests checked against the model
    for (int i = 0; i < 8; i++) begin
      logic [2:0] op;
      logic [3:0] a, b;
      int p;
      p  = $urandom_range(0, 1);
      op = 3'($urandom_range(0, 7));
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      send(p, op, a, b, model(op, a, b), 1'b1);
      wait_idle();
    end

    // response hold with owner not ready; non-owner ready is ignored
    @(negedge clk);
    rsp_ready = 2'b01;
    send(1, 3'd6, 4'hA, 4'h6, 11'h00C, 1'b1);
    #1;
    set_port(0, 3'd4, 4'hF, 4'h5);
    req_valid = 2'b01;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid",  32'(rsp_valid),  32'd2);
      check("hold_result", 32'(rsp_result), 32'h0C);
      check("hold_flags",  32'({rsp_dz, rsp_ovf, rsp_carry}), 32'd0);
      check("hold_ready",  32'(req_ready),  32'd0);
      if (i == 4) rsp_ready = 2'b11;
      else begin
        @(negedge clk); #1;
      end
    end
    @(negedge clk); #1;
    check("next_accept_ready", 32'(req_ready), 32'd1);
    exp_q.push_back(11'h005);
    port_q.push_back(0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check("next_exec", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("next_resp", 32'(rsp_valid), 32'd1);
    wait_idle();

    // reset during EXEC: port 0 accepted, so port 1 would win a tie without reset
    @(negedge clk);
    set_port(0, 3'd0, 4'd9, 4'd8);
    req_valid = 2'b01; #1;
    check("pre_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("exec_rst_valid",  32'(rsp_valid),  32'd0);
    check("exec_rst_result", 32'(rsp_result), 32'd0);
    check("exec_rst_flags",  32'({rsp_dz, rsp_ovf, rsp_carry}), 32'd0);
    rst = 1'b0;
    set_port(0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    set_port(1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    req_valid = 2'b11;
    #1;

    // fairness: both ports continuously valid, grants alternate from port 0
    k = 0;
    n = 0;
    while (k < 6 && n < 60) begin
      if (req_ready != 2'b00) begin
        int g;
        check("grant_order", 32'(req_ready), k[0] ? 32'd2 : 32'd1);
        g = req_ready[1] ? 1 : 0;
        exp_q.push_back(model(req_op[g*3 +: 3], req_a[g*4 +: 4], req_b[g*4 +: 4]));
        port_q.push_back(g);
        k++;
        @(posedge clk); #1;
        set_port(g, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      @(negedge clk); #1;
      n++;
    end
    if (k < 6) check("fair_timeout", 32'(k), 32'd6);
    req_valid = 2'b00;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
